// File: rtl/mem_master.sv
// CPU-side load/store initiator for the byte-addressed block RAM.
// One request at a time: range check, one-cycle RAM strobe, load capture and extend.
module mem_master #(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 16
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_req,
  output logic              O_ready,
  input  logic              I_we,
  input  logic [1:0]        I_size,
  input  logic              I_signed,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [15:0]       I_wdata,
  output logic              O_done,
  output logic              O_fault,
  output logic [15:0]       O_rdata,
  output logic              O_ram_enable,
  output logic              O_ram_write,
  output logic [1:0]        O_ram_size,
  output logic [15:0]       O_ram_addr,
  output logic [15:0]       O_ram_wdata,
  input  logic [15:0]       I_ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W:0] LP_LIM = (ADDR_W+1)'(MEM_BYTES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_signed;
  logic              w_accept;
  logic              w_legal;
  logic              w_size_ok;
  logic [ADDR_W:0]   w_addr_x;
  logic [ADDR_W:0]   w_addr_p1;
  logic [15:0]       w_ext;

  assign O_ready  = I_reset && (r_state == ST_IDLE);
  assign w_accept = O_ready && I_req;

  // addr+1 is one bit wider so the top address cannot wrap back into range
  assign w_addr_x  = {1'b0, I_addr};
  assign w_addr_p1 = w_addr_x + (ADDR_W+1)'(1);
  assign w_size_ok = (I_size == 2'd1) || (I_size == 2'd2);
  assign w_legal   = w_size_ok
                   && (w_addr_x < LP_LIM)
                   && !((I_size == 2'd2) && (w_addr_p1 >= LP_LIM));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_legal ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE:   w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_ext = I_ram_rdata;
    unique case (1'b1)
      (O_ram_size == 2'd1) && r_signed:
        w_ext = {{8{I_ram_rdata[7]}}, I_ram_rdata[7:0]};
      (O_ram_size == 2'd1) && !r_signed:
        w_ext = {8'h00, I_ram_rdata[7:0]};
      default:
        w_ext = I_ram_rdata;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      O_ram_enable <= 1'b0;
      O_ram_write  <= 1'b0;
      O_ram_size   <= 2'd1;
      O_ram_addr   <= '0;
      O_ram_wdata  <= '0;
      O_done       <= 1'b0;
      O_fault      <= 1'b0;
      O_rdata      <= '0;
      r_signed     <= 1'b0;
    end else begin
      O_ram_enable <= (w_state_nxt == ST_ISSUE);
      O_done       <= (w_state_nxt == ST_DONE);
      O_fault      <= w_accept && !w_legal;
      if (w_accept) begin
        r_signed <= I_signed;
        // rejected requests leave the RAM port untouched
        if (w_legal) begin
          O_ram_write <= I_we;
          O_ram_size  <= I_size;
          O_ram_addr  <= 16'(I_addr);
          O_ram_wdata <= I_wdata;
        end
      end
      if ((r_state == ST_CAPTURE) && !O_ram_write) begin
        O_rdata <= w_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master with a behavioural block RAM.
// Expectations are queued at accept and checked at RAM strobe / completion.
module tb_mem_master;

  logic        I_clk;
  logic        I_reset;
  logic        I_req;
  logic        O_ready;
  logic        I_we;
  logic [1:0]  I_size;
  logic        I_signed;
  logic [15:0] I_addr;
  logic [15:0] I_wdata;
  logic        O_done;
  logic        O_fault;
  logic [15:0] O_rdata;
  logic        O_ram_enable;
  logic        O_ram_write;
  logic [1:0]  O_ram_size;
  logic [15:0] O_ram_addr;
  logic [15:0] O_ram_wdata;
  logic [15:0] I_ram_rdata;

  mem_master #(.MEM_BYTES(2048), .ADDR_W(16)) dut (
    .I_clk(I_clk),
    .I_reset(I_reset),
    .I_req(I_req),
    .O_ready(O_ready),
    .I_we(I_we),
    .I_size(I_size),
    .I_signed(I_signed),
    .I_addr(I_addr),
    .I_wdata(I_wdata),
    .O_done(O_done),
    .O_fault(O_fault),
    .O_rdata(O_rdata),
    .O_ram_enable(O_ram_enable),
    .O_ram_write(O_ram_write),
    .O_ram_size(O_ram_size),
    .O_ram_addr(O_ram_addr),
    .O_ram_wdata(O_ram_wdata),
    .I_ram_rdata(I_ram_rdata)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  logic [7:0]  ram   [0:2047];
  logic [7:0]  m_mem [0:2047];
  logic [15:0] ram_rdata;
  assign I_ram_rdata = ram_rdata;

  always @(posedge I_clk) begin
    if (O_ram_enable) begin
      if (O_ram_write) begin
        ram[O_ram_addr[10:0]] <= O_ram_wdata[7:0];
        if (O_ram_size == 2'd2)
          ram[O_ram_addr[10:0] + 11'd1] <= O_ram_wdata[15:8];
      end else begin
        ram_rdata <= {ram[O_ram_addr[10:0] + 11'd1], ram[O_ram_addr[10:0]]};
      end
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [15:0] wdata;
  } ram_exp_t;

  typedef struct {
    logic        fault;
    logic        keep;
    logic [15:0] rdata;
    int          acc;
  } done_exp_t;

  ram_exp_t  rq[$];
  done_exp_t dq[$];

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          last_acc = -1;
  bit          b2b = 1'b0;
  logic [15:0] m_rdata = 16'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [1:0] sz, input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (sz != 2'd1 && sz != 2'd2) return 1'b0;
    if (ai >= 2048) return 1'b0;
    if (sz == 2'd2 && ai + 1 >= 2048) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] mrd(input logic [15:0] a,
                                      input logic [1:0] sz, input logic sg);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = m_mem[a[10:0]];
    hi = m_mem[a[10:0] + 11'd1];
    if (sz == 2'd2) return {hi, lo};
    if (sg) return {{8{lo[7]}}, lo};
    return {8'h00, lo};
  endfunction

  always @(negedge I_clk) begin : mon
    ram_exp_t    r;
    done_exp_t   d;
    logic [15:0] e;
    bit          lg;
    cyc++;
    if (O_ram_enable) begin
      if (rq.size() == 0) begin
        chk("spur_en", 1, 0);
      end else begin
        r = rq.pop_front();
        chk("ram_we", O_ram_write, r.we);
        chk("ram_sz", O_ram_size, r.size);
        chk("ram_addr", O_ram_addr, r.addr);
        if (r.we) chk("ram_wdata", O_ram_wdata, r.wdata);
      end
    end
    if (O_done) begin
      if (dq.size() == 0) begin
        chk("spur_done", 1, 0);
      end else begin
        d = dq.pop_front();
        chk("latency", cyc - d.acc, d.fault ? 1 : 3);
        chk("fault", O_fault, d.fault);
        chk("en_left", rq.size(), 0);
        e = d.keep ? m_rdata : d.rdata;
        chk("rdata", O_rdata, e);
        m_rdata = e;
      end
    end else if (dq.size() != 0 && cyc - dq[0].acc > 8) begin
      chk("done_to", 0, 1);
      void'(dq.pop_front());
    end
    if (!I_reset) begin
      dq.delete();
      rq.delete();
      m_rdata = 16'h0;
    end else if (O_ready && I_req) begin
      n_acc++;
      if (b2b && last_acc >= 0) chk("b2b_gap", cyc - last_acc, 4);
      last_acc = cyc;
      lg = legal(I_size, I_addr);
      d.fault = !lg;
      d.keep  = !lg || I_we;
      d.rdata = (lg && !I_we) ? mrd(I_addr, I_size, I_signed) : 16'h0;
      d.acc   = cyc;
      dq.push_back(d);
      if (lg) begin
        r.we = I_we;
        r.size = I_size;
        r.addr = I_addr;
        r.wdata = I_wdata;
        rq.push_back(r);
        if (I_we) begin
          m_mem[I_addr[10:0]] = I_wdata[7:0];
          if (I_size == 2'd2) m_mem[I_addr[10:0] + 11'd1] = I_wdata[15:8];
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int k;
    k = 0;
    @(posedge I_clk) #1;
    while (!O_ready && k < 50) begin
      @(posedge I_clk) #1;
      k++;
    end
    ok = O_ready;
    if (!ok) chk("ready_to", 0, 1);
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [15:0] a, input logic [15:0] wd);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    I_we = we;
    I_size = sz;
    I_signed = sg;
    I_addr = a;
    I_wdata = wd;
    I_req = 1'b1;
    @(posedge I_clk) #1;
    I_req = 1'b0;
    I_we = ~we;
    I_size = 2'($urandom);
    I_signed = ~sg;
    I_addr = 16'($urandom);
    I_wdata = 16'($urandom);
  endtask

  initial begin
    bit          ok;
    int          base;
    int          k;
    int          rr;
    logic [1:0]  sz;
    logic [15:0] a;
    I_reset = 1'b0;
    I_req = 1'b0;
    I_we = 1'b0;
    I_size = 2'd1;
    I_signed = 1'b0;
    I_addr = 16'h0;
    I_wdata = 16'h0;
    ram_rdata = 16'h0;
    for (int i = 0; i < 2048; i++) begin
      ram[i] = 8'($urandom);
      m_mem[i] = ram[i];
    end
    repeat (3) @(posedge I_clk);
    @(negedge I_clk);
    chk("rst_ready", O_ready, 0);
    chk("rst_en", O_ram_enable, 0);
    chk("rst_write", O_ram_write, 0);
    chk("rst_done", O_done, 0);
    chk("rst_fault", O_fault, 0);
    chk("rst_rdata", O_rdata, 0);
    chk("rst_addr", O_ram_addr, 0);
    chk("rst_wdata", O_ram_wdata, 0);
    chk("rst_size", O_ram_size, 1);
    @(posedge I_clk) #1;
    I_reset = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 16'h1234);
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 16'h0000);
    do_req(1'b1, 2'd1, 1'b0, 16'h0020, 16'hAB80);
    do_req(1'b0, 2'd1, 1'b1, 16'h0020, 16'h0000);
    do_req(1'b0, 2'd1, 1'b0, 16'h0020, 16'h0000);
    do_req(1'b0, 2'd2, 1'b0, 16'h07FF, 16'h0000);
    do_req(1'b0, 2'd1, 1'b0, 16'h0800, 16'h0000);
    do_req(1'b0, 2'd3, 1'b0, 16'h0000, 16'h0000);
    do_req(1'b1, 2'd0, 1'b0, 16'h0004, 16'h5555);
    do_req(1'b0, 2'd2, 1'b0, 16'hFFFF, 16'h0000);
    do_req(1'b0, 2'd1, 1'b1, 16'h07FF, 16'h0000);
    do_req(1'b0, 2'd2, 1'b1, 16'h07FE, 16'h0000);

    // reset lands on the edge that ends ISSUE
    wait_ready(ok);
    I_we = 1'b0;
    I_size = 2'd2;
    I_signed = 1'b0;
    I_addr = 16'h0010;
    I_req = 1'b1;
    @(posedge I_clk) #1;
    I_req = 1'b0;
    I_reset = 1'b0;
    @(negedge I_clk);
    chk("iss_en", O_ram_enable, 1);
    repeat (3) begin
      @(negedge I_clk);
      chk("rst_iss_en", O_ram_enable, 0);
      chk("rst_iss_rdy", O_ready, 0);
      chk("rst_iss_done", O_done, 0);
    end
    @(posedge I_clk) #1;
    I_reset = 1'b1;
    @(negedge I_clk);
    chk("rel_ready", O_ready, 1);

    // held request: inputs move to the next request right after each accept
    wait_ready(ok);
    b2b = 1'b1;
    last_acc = -1;
    base = n_acc;
    I_we = 1'b0;
    I_size = 2'd2;
    I_signed = 1'b0;
    I_addr = 16'h0010;
    I_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (n_acc == base + i && k < 20) begin
        @(posedge I_clk) #1;
        k++;
      end
      if (k >= 20) chk("b2b_to", 0, 1);
      if (i == 0) begin
        I_size = 2'd1;
        I_signed = 1'b1;
        I_addr = 16'h0020;
      end else if (i == 1) begin
        I_size = 2'd2;
        I_signed = 1'b0;
        I_addr = 16'h07FE;
      end else begin
        I_req = 1'b0;
        I_addr = 16'h0123;
      end
    end
    chk("b2b_count", n_acc - base, 3);
    b2b = 1'b0;

    for (int i = 0; i < 30; i++) begin
      rr = int'($urandom_range(0, 7));
      sz = (rr < 3) ? 2'd1 : (rr < 6) ? 2'd2 : (rr == 6) ? 2'd0 : 2'd3;
      if ($urandom_range(0, 5) == 0) a = 16'h07F0 + 16'($urandom_range(0, 31));
      else a = 16'($urandom_range(0, 63));
      do_req(1'($urandom), sz, 1'($urandom), a, 16'($urandom));
    end

    repeat (10) @(posedge I_clk);
    @(negedge I_clk);
    chk("drain_done", dq.size(), 0);
    chk("drain_ram", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
